// File: rtl/beat_sequencer.sv
// Tempo/beat-position controller: single-clock phase accumulator producing the
// song ROM beat index, with play/pause/stop transport and loop/one-shot playback.
module beat_sequencer #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BEAT_LEN = 128,
    parameter int unsigned IDX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play,
    input  logic             pause,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [27:0]      beat_freq,
    output logic [IDX_W-1:0] ibeat,
    output logic             beat_tick,
    output logic             playing,
    output logic             done,
    output logic             mute
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [27:0]      CLK_F     = 28'(CLK_FREQ);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEAT_LEN - 1);

    state_t           state_q, state_d;
    logic [27:0]      acc_q, acc_d;
    logic [IDX_W-1:0] ibeat_q, ibeat_d;
    logic             beat_tick_q, beat_tick_d;
    logic             playing_q, playing_d;
    logic             done_q, done_d;
    logic             mute_q, mute_d;

    logic [27:0]      f_sat;
    logic [27:0]      sum;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ibeat_d     = ibeat_q;
        beat_tick_d = 1'b0;

        // Saturating the tempo keeps acc+f below 2*CLK_FREQ, so 28 bits never overflow.
        f_sat = (beat_freq > CLK_F) ? CLK_F : beat_freq;
        sum   = acc_q + f_sat;

        if (stop) begin
            state_d = IDLE;
            acc_d   = '0;
            ibeat_d = '0;
        end else if (pause) begin
            if (state_q == PLAY) begin
                state_d = PAUSE;
            end
        end else if (play) begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = PLAY;
                    acc_d   = '0;
                    ibeat_d = '0;
                end
                PAUSE:   state_d = PLAY;
                default: state_d = state_q;
            endcase
        end else if (state_q == PLAY) begin
            if (sum >= CLK_F) begin
                acc_d = sum - CLK_F;
                if (ibeat_q != LAST_BEAT) begin
                    ibeat_d     = ibeat_q + 1'b1;
                    beat_tick_d = 1'b1;
                end else if (loop_en) begin
                    ibeat_d     = '0;
                    beat_tick_d = 1'b1;
                end else begin
                    // One-shot end: park on the last beat with a clean phase.
                    state_d = DONE;
                    acc_d   = '0;
                end
            end else begin
                acc_d = sum;
            end
        end

        playing_d = (state_d == PLAY);
        done_d    = (state_d == DONE);
        mute_d    = (state_d != PLAY);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ibeat_q     <= '0;
            beat_tick_q <= 1'b0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
            mute_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ibeat_q     <= ibeat_d;
            beat_tick_q <= beat_tick_d;
            playing_q   <= playing_d;
            done_q      <= done_d;
            mute_q      <= mute_d;
        end
    end

    assign ibeat     = ibeat_q;
    assign beat_tick = beat_tick_q;
    assign playing   = playing_q;
    assign done      = done_q;
    assign mute      = mute_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed vector table, corner-case
// sequences and randomized transport/tempo stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_beat_sequencer;

    localparam int CLK_F = 16;
    localparam int BL    = 4;
    localparam int IW    = 3;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset, play, pause, stop, loop_en;
    logic [27:0]   beat_freq;
    logic [IW-1:0] ibeat;
    logic          beat_tick, playing, done, mute;

    always #5 clk = ~clk;

    beat_sequencer #(
        .CLK_FREQ(CLK_F),
        .BEAT_LEN(BL),
        .IDX_W   (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .play     (play),
        .pause    (pause),
        .stop     (stop),
        .loop_en  (loop_en),
        .beat_freq(beat_freq),
        .ibeat    (ibeat),
        .beat_tick(beat_tick),
        .playing  (playing),
        .done     (done),
        .mute     (mute)
    );

    typedef struct {
        logic        r, pl, pa, st, le;
        logic [27:0] bf;
        logic [2:0]  ib;
        logic        tk, py, dn, mu;
    } vec_t;

    vec_t tbl[$];

    int          n_vec = 0;
    int          n_bad = 0;
    int          m_mode = M_IDLE;
    int          m_acc = 0;
    int          m_pos = 0;
    logic        m_tick = 1'b0;
    logic        cur_le;
    logic [27:0] cur_bf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position counts whole beats, acc is the fractional phase in clock units.
    task automatic model_step(input logic r, input logic pl, input logic pa, input logic st,
                              input logic le, input logic [27:0] bf);
        int f;
        m_tick = 1'b0;
        if (!r) begin
            m_mode = M_IDLE; m_acc = 0; m_pos = 0;
        end else if (st) begin
            m_mode = M_IDLE; m_acc = 0; m_pos = 0;
        end else if (pa) begin
            if (m_mode == M_PLAY) m_mode = M_PAUSE;
        end else if (pl) begin
            if (m_mode == M_IDLE || m_mode == M_DONE) begin
                m_mode = M_PLAY; m_acc = 0; m_pos = 0;
            end else if (m_mode == M_PAUSE) begin
                m_mode = M_PLAY;
            end
        end else if (m_mode == M_PLAY) begin
            f = (bf > 28'(CLK_F)) ? CLK_F : int'(bf);
            m_acc = m_acc + f;
            if (m_acc >= CLK_F) begin
                m_acc = m_acc - CLK_F;
                if (m_pos < BL - 1) begin
                    m_pos++; m_tick = 1'b1;
                end else if (le) begin
                    m_pos = 0; m_tick = 1'b1;
                end else begin
                    m_mode = M_DONE; m_acc = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic pl, input logic pa, input logic st,
                        input logic le, input logic [27:0] bf);
        reset = r; play = pl; pause = pa; stop = st; loop_en = le; beat_freq = bf;
        @(posedge clk);
        model_step(r, pl, pa, st, le, bf);
        #1;
        check("model", {25'd0, ibeat, beat_tick, playing, done, mute},
              {25'd0, 3'(m_pos), m_tick, m_mode == M_PLAY, m_mode == M_DONE, m_mode != M_PLAY});
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, cur_le, cur_bf);
    endtask

    task automatic cmd(input logic pl, input logic pa, input logic st);
        step(1'b1, pl, pa, st, cur_le, cur_bf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int   cnt;
        int   last;
        int   gap_pat[3];
        int   held;
        int   bad;
        int   bf_pool[12];

        reset = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0; beat_freq = 28'd4;
        cur_le = 1'b0; cur_bf = 28'd4;

        // r pl pa st le bf | ibeat tick playing done mute
        tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,28'd4, 3'd0,1'b0,1'b0,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,28'd4, 3'd0,1'b0,1'b1,1'b0,1'b0});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,28'd4, 3'd0,1'b0,1'b1,1'b0,1'b0});
        for (int b = 1; b < 4; b++) begin
            tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,28'd4, 3'(b),1'b1,1'b1,1'b0,1'b0});
            for (int i = 0; i < 3; i++) tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,28'd4, 3'(b),1'b0,1'b1,1'b0,1'b0});
        end
        tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,28'd4, 3'd3,1'b0,1'b0,1'b1,1'b1});
        tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,28'd4, 3'd3,1'b0,1'b0,1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,28'd4, 3'd0,1'b0,1'b1,1'b0,1'b0});
        tbl.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0,28'd4, 3'd0,1'b0,1'b0,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,28'd4, 3'd0,1'b0,1'b0,1'b0,1'b1});
        tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,28'd4, 3'd0,1'b0,1'b0,1'b0,1'b1});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].pl, tbl[i].pa, tbl[i].st, tbl[i].le, tbl[i].bf);
            check($sformatf("table[%0d]", i), {27'd0, ibeat, beat_tick, playing, done, mute},
                  {27'd0, tbl[i].ib, tbl[i].tk, tbl[i].py, tbl[i].dn, tbl[i].mu});
        end

        // Looping playback: six ticks in 24 cycles, index wraps, never done.
        cur_le = 1'b1; cur_bf = 28'd4;
        cmd(1'b1, 1'b0, 1'b0);
        cnt = 0; bad = 0;
        for (int c = 0; c < 24; c++) begin
            idle();
            if (done) bad++;
            if (beat_tick) begin
                cnt++;
                check("loop_seq", 32'(ibeat), 32'(cnt % BL));
            end
        end
        check("loop_ticks", cnt, 6);
        check("loop_done", bad, 0);

        // Fractional tempo: gaps 3,3,2 and exactly 18 ticks in 48 cycles.
        cmd(1'b0, 1'b0, 1'b1);
        cur_bf = 28'd6;
        cmd(1'b1, 1'b0, 1'b0);
        gap_pat[0] = 3; gap_pat[1] = 3; gap_pat[2] = 2;
        cnt = 0; last = 0;
        for (int c = 1; c <= 48; c++) begin
            idle();
            if (beat_tick) begin
                check("frac_gap", c - last, gap_pat[cnt % 3]);
                last = c;
                cnt++;
            end
        end
        check("frac_ticks", cnt, 18);
        check("frac_last", last, 48);
        check("frac_ibeat", 32'(ibeat), 32'd2);

        // Pause two cycles after a tick, hold 10 cycles, resume.
        cmd(1'b0, 1'b0, 1'b1);
        cur_bf = 28'd4;
        cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !beat_tick; i++) idle();
        check("pause_wait_tick", 32'(beat_tick), 32'd1);
        held = int'(ibeat);
        idle(); idle();
        cmd(1'b0, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (int'(ibeat) != held || beat_tick || !mute || playing) bad++;
        end
        check("pause_hold", bad, 0);
        cmd(1'b1, 1'b0, 1'b0);
        check("resume_playing", 32'(playing), 32'd1);
        idle();
        check("resume_tick1", 32'(beat_tick), 32'd0);
        idle();
        check("resume_tick2", 32'(beat_tick), 32'd1);
        check("resume_ibeat", 32'(ibeat), 32'((held + 1) % BL));

        // All three commands at once: stop wins.
        idle(); idle(); idle(); idle();
        cmd(1'b1, 1'b1, 1'b1);
        check("all_cmds", {29'd0, ibeat}, 32'd0);
        check("all_cmds_mute", {30'd0, playing, mute}, 32'b01);

        // Reset in mid-song while play is also pulsed.
        cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, cur_le, cur_bf);
        check("reset_mid", {25'd0, ibeat, beat_tick, playing, done, mute}, 32'b0000_0001);

        // Over-range tempo saturates to a tick every cycle.
        cur_bf = 28'd20;
        cmd(1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (beat_tick) cnt++;
        end
        check("fast_ticks", cnt, 8);

        // Zero tempo: no ticks at all.
        cmd(1'b0, 1'b0, 1'b1);
        cur_bf = 28'd0;
        cmd(1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (beat_tick) cnt++;
        end
        check("zero_ticks", cnt, 0);
        check("zero_ibeat", 32'(ibeat), 32'd0);

        // Randomized transport and tempo against the model.
        bf_pool[0] = 0;  bf_pool[1] = 1;  bf_pool[2] = 3;  bf_pool[3] = 4;
        bf_pool[4] = 6;  bf_pool[5] = 9;  bf_pool[6] = 15; bf_pool[7] = 16;
        bf_pool[8] = 17; bf_pool[9] = 20; bf_pool[10] = 'h0FFFFFF; bf_pool[11] = 11;
        for (int c = 0; c < 600; c++) begin
            if (c % 40 == 0) begin
                cur_le = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) cur_bf = 28'($urandom);
                else cur_bf = 28'(bf_pool[$urandom_range(0, 11)]);
            end
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 59) == 0,
                 cur_le, cur_bf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
